// File: rtl/mipi_rx_raw_depacker_multi_if.sv
// Byte-stream input and pixel-beat output of the multi-mode RAW depacker.
// The master drives the lane bytes; the slave (depacker) drives the pixel side.
interface mipi_rx_raw_depacker_multi_if #(
    parameter int unsigned PIXEL_WIDTH = 12,
    parameter int unsigned CNT_WIDTH   = 16
);
    logic                       line_valid_i;
    logic                       data_valid_i;
    logic [31:0]                data_i;
    logic [1:0]                 raw_mode_i;
    logic                       output_valid_o;
    logic [4*PIXEL_WIDTH-1:0]   output_o;
    logic [CNT_WIDTH-1:0]       line_pixels_o;
    logic                       line_done_o;
    logic                       partial_err_o;

    modport master (
        output line_valid_i, data_valid_i, data_i, raw_mode_i,
        input  output_valid_o, output_o, line_pixels_o, line_done_o, partial_err_o
    );

    modport slave (
        input  line_valid_i, data_valid_i, data_i, raw_mode_i,
        output output_valid_o, output_o, line_pixels_o, line_done_o, partial_err_o
    );
endinterface

// File: rtl/mipi_rx_raw_depacker_multi.sv
// Unpacks 4-lane CSI-2 RAW8/RAW10/RAW12 payload into 4 MSB-aligned pixels per beat,
// with per-line mode latch, residual-byte error flag and per-line pixel count.
module mipi_rx_raw_depacker_multi #(
    parameter int unsigned PIXEL_WIDTH = 12,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    mipi_rx_raw_depacker_multi_if.slave  bus_if
);
    typedef enum logic [1:0] {
        ModeRaw8  = 2'd0,
        ModeRaw10 = 2'd1,
        ModeRaw12 = 2'd2,
        ModeRsvd  = 2'd3
    } mode_e;

    logic                     lv_q;
    mode_e                    mode_q, mode_d, mode_eff;
    logic [79:0]              buf_q, buf_d, comb;
    logic [3:0]               count_q, count_d, n, g;
    logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;
    logic [CNT_WIDTH:0]       cnt_sum;
    logic [4*PIXEL_WIDTH-1:0] out_q, out_d, pix_word;
    logic                     valid_q, valid_d;
    logic                     done_q, done_d;
    logic [CNT_WIDTH-1:0]     lp_q, lp_d;
    logic                     err_q, err_d;
    logic                     rise, fall;
    logic [15:0]              aligned;

    assign rise     = bus_if.line_valid_i & ~lv_q;
    assign fall     = ~bus_if.line_valid_i & lv_q;
    // The first word of a line is decoded with the mode sampled on that same cycle.
    assign mode_eff = rise ? mode_e'(bus_if.raw_mode_i) : mode_q;

    // Bytes above count_q are kept zero, so appending is a plain OR.
    assign comb    = buf_q | (80'(bus_if.data_i) << {count_q, 3'b000});
    assign n       = count_q + 4'd4;
    assign cnt_sum = {1'b0, cnt_q} + {{(CNT_WIDTH - 2){1'b0}}, 3'd4};

    always_comb begin
        g = 4'd4;
        unique case (mode_eff)
            ModeRaw8:  g = 4'd4;
            ModeRaw10: g = 4'd5;
            ModeRaw12: g = 4'd6;
            default:   g = 4'd4;
        endcase
    end

    always_comb begin
        pix_word = '0;
        aligned  = '0;
        for (int k = 0; k < 4; k++) begin
            unique case (mode_eff)
                ModeRaw8:  aligned = {comb[8*k +: 8], 8'h00};
                ModeRaw10: aligned = {comb[8*k +: 8], comb[32 + 2*k +: 2], 6'h00};
                ModeRaw12: begin
                    if (k < 2) aligned = {comb[8*k +: 8], comb[16 + 4*k +: 4], 4'h0};
                    else       aligned = {comb[8*(k+1) +: 8], comb[40 + 4*(k-2) +: 4], 4'h0};
                end
                default:   aligned = '0;
            endcase
            pix_word[k*PIXEL_WIDTH +: PIXEL_WIDTH] = PIXEL_WIDTH'(aligned >> (16 - PIXEL_WIDTH));
        end
    end

    always_comb begin
        buf_d   = buf_q;
        count_d = count_q;
        mode_d  = mode_eff;
        cnt_d   = cnt_q;
        out_d   = out_q;
        valid_d = 1'b0;
        done_d  = 1'b0;
        lp_d    = lp_q;
        err_d   = err_q;

        if (bus_if.line_valid_i && bus_if.data_valid_i && mode_eff != ModeRsvd) begin
            if (n >= g) begin
                buf_d   = comb >> {g, 3'b000};
                count_d = n - g;
                out_d   = pix_word;
                valid_d = 1'b1;
                cnt_d   = cnt_sum[CNT_WIDTH] ? '1 : cnt_sum[CNT_WIDTH-1:0];
            end else begin
                buf_d   = comb;
                count_d = n;
            end
        end

        if (fall) begin
            lp_d    = cnt_q;
            done_d  = 1'b1;
            if (count_q != 4'd0 || mode_q == ModeRsvd) err_d = 1'b1;
            buf_d   = '0;
            count_d = 4'd0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            lv_q    <= 1'b0;
            mode_q  <= ModeRaw10;
            buf_q   <= '0;
            count_q <= 4'd0;
            cnt_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            lp_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            lv_q    <= bus_if.line_valid_i;
            mode_q  <= mode_d;
            buf_q   <= buf_d;
            count_q <= count_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            lp_q    <= lp_d;
            err_q   <= err_d;
        end
    end

    assign bus_if.output_valid_o = valid_q;
    assign bus_if.output_o       = out_q;
    assign bus_if.line_pixels_o  = lp_q;
    assign bus_if.line_done_o    = done_q;
    assign bus_if.partial_err_o  = err_q;
endmodule
